// File: rtl/nanov_regfile_serial.sv
// Digit-serial register file for the nanoV core: NREGS words of XLEN bits, streamed
// DIGIT bits per cycle (LSB digit first) on two read ports and one write port.
module nanov_regfile_serial #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 16,
    parameter int DIGIT    = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = (NREGS > 1) ? $clog2(NREGS) : 1,
    localparam int NDIG    = XLEN / DIGIT,
    localparam int CW      = $clog2(NDIG)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             pause,
    input  logic             wr_en,
    input  logic [AW-1:0]    rs1,
    input  logic [AW-1:0]    rs2,
    input  logic [AW-1:0]    rd,
    input  logic [DIGIT-1:0] data_rd,
    output logic [DIGIT-1:0] data_rs1,
    output logic [DIGIT-1:0] data_rs2,
    output logic [CW-1:0]    digit_idx,
    output logic             word_start,
    output logic             word_last
);
    localparam int OW        = $clog2(XLEN);
    localparam bit HARD_ZERO = (ZERO_REG == 1);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic [CW-1:0]   digit_idx_q;
    logic [CW-1:0]   digit_idx_d;
    logic [OW-1:0]   bit_off_s;
    logic            last_s;

    // Wrap is an explicit compare so non-power-of-two digit counts never overflow into a gap.
    assign last_s     = (digit_idx_q == CW'(NDIG - 1));
    assign bit_off_s  = OW'(digit_idx_q) * OW'(DIGIT);
    assign digit_idx  = digit_idx_q;
    assign word_start = (digit_idx_q == '0);
    assign word_last  = last_s;

    // Read mux: unmatched addresses (>= NREGS) and a hard-wired x0 fall through to zero.
    always_comb begin
        data_rs1 = '0;
        data_rs2 = '0;
        for (int i = 0; i < NREGS; i++) begin
            data_rs1 = (!(HARD_ZERO && i == 0) && rs1 == AW'(i)) ?
                       regs_q[i][bit_off_s +: DIGIT] : data_rs1;
            data_rs2 = (!(HARD_ZERO && i == 0) && rs2 == AW'(i)) ?
                       regs_q[i][bit_off_s +: DIGIT] : data_rs2;
        end
    end

    // Next-state: counter advance and single-digit write, both frozen by pause.
    always_comb begin
        regs_d = regs_q;
        if (pause) begin
            digit_idx_d = digit_idx_q;
        end else begin
            digit_idx_d = last_s ? '0 : digit_idx_q + CW'(1);
            for (int i = 0; i < NREGS; i++) begin
                regs_d[i][bit_off_s +: DIGIT] =
                    (wr_en && !(HARD_ZERO && i == 0) && rd == AW'(i)) ?
                    data_rd : regs_q[i][bit_off_s +: DIGIT];
            end
        end
    end

    // State registers; reset discards any partially written word.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            digit_idx_q <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            digit_idx_q <= digit_idx_d;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

endmodule
